// File: rtl/servo_bank_ctrl.sv
// servo_bank_ctrl: NUM_CH slew-limited servo PWM channels driven by
// per-channel inc/dec buttons or a valid/ready target command port.
module servo_bank_ctrl #(
  parameter int unsigned SYS_CLK   = 50000000,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PERIOD_US = 2500,
  parameter int unsigned MIN_US    = 1000,
  parameter int unsigned MAX_US    = 2000,
  parameter int unsigned STEP_US   = 1,
  parameter int unsigned SLEW_US   = 10,
  parameter int unsigned RAMP_HZ   = 100,
  parameter int unsigned W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] inc,
  input  logic [NUM_CH-1:0] dec,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_ch,
  input  logic [W-1:0]      cmd_width,
  output logic [NUM_CH-1:0] servo,
  output logic [NUM_CH-1:0] max_lim,
  output logic [NUM_CH-1:0] min_lim
);

  localparam int unsigned DIV      = SYS_CLK / 1000000;
  localparam int unsigned RAMP_DIV = 1000000 / RAMP_HZ;
  localparam int unsigned PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned RW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned MID      = (MIN_US + MAX_US) / 2;

  logic [PW-1:0]     r_presc;
  logic [W-1:0]      r_period;
  logic [RW-1:0]     r_ramp;
  logic              r_cmd_ready;
  logic [W-1:0]      r_tgt     [NUM_CH];
  logic [W-1:0]      r_cur     [NUM_CH];
  logic [W-1:0]      r_width_q [NUM_CH];
  logic [NUM_CH-1:0] r_servo;
  logic [NUM_CH-1:0] r_max_lim;
  logic [NUM_CH-1:0] r_min_lim;

  logic              w_us_tick;
  logic              w_wrap;
  logic              w_ramp_tick;
  logic              w_cmd_fire;
  logic [W-1:0]      w_cmd_tgt;
  logic [NUM_CH-1:0] w_cmd_hit;
  logic [W-1:0]      w_btn_tgt  [NUM_CH];
  logic [W-1:0]      w_slew_cur [NUM_CH];

  // Clamp a W+1 bit value into [MIN_US, MAX_US]; the extra bit absorbs overflow.
  function automatic logic [W-1:0] f_clamp(input logic [W:0] v);
    logic [W-1:0] r;
    if (v < (W+1)'(MIN_US))      r = W'(MIN_US);
    else if (v > (W+1)'(MAX_US)) r = W'(MAX_US);
    else                         r = v[W-1:0];
    return r;
  endfunction

  // Button update of one target; both buttons together recentre the channel.
  function automatic logic [W-1:0] f_btn(input logic [W-1:0] tgt, input logic up, input logic dn);
    logic [W:0]   t;
    logic [W-1:0] r;
    t = {1'b0, tgt};
    if (up && dn)  r = W'(MID);
    else if (up)   r = f_clamp(t + (W+1)'(STEP_US));
    else if (dn)   r = (t < (W+1)'(MIN_US) + (W+1)'(STEP_US)) ? W'(MIN_US)
                                                              : f_clamp(t - (W+1)'(STEP_US));
    else           r = tgt;
    return r;
  endfunction

  // Move current width toward target by at most SLEW_US.
  function automatic logic [W-1:0] f_slew(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic [W:0]   c;
    logic [W:0]   t;
    logic [W:0]   d;
    logic [W-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    if (t > c) begin
      d = t - c;
      if (d > (W+1)'(SLEW_US)) d = (W+1)'(SLEW_US);
      r = f_clamp(c + d);
    end else begin
      d = c - t;
      if (d > (W+1)'(SLEW_US)) d = (W+1)'(SLEW_US);
      r = f_clamp(c - d);
    end
    return r;
  endfunction

  assign w_us_tick   = (r_presc == PW'(DIV - 1));
  assign w_wrap      = w_us_tick && (r_period == W'(PERIOD_US - 1));
  assign w_ramp_tick = w_us_tick && (r_ramp == RW'(RAMP_DIV - 1));
  assign w_cmd_fire  = cmd_valid && r_cmd_ready;
  assign w_cmd_tgt   = f_clamp({1'b0, cmd_width});

  // Per-channel command decode, button target and slew step.
  always_comb begin
    w_cmd_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_cmd_hit[i]  = w_cmd_fire && (cmd_ch == 4'(i));
      w_btn_tgt[i]  = f_btn(r_tgt[i], inc[i], dec[i]);
      w_slew_cur[i] = f_slew(r_cur[i], r_tgt[i]);
    end
  end

  // Microsecond prescaler, frame counter and ramp divider.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc     <= '0;
      r_period    <= '0;
      r_ramp      <= '0;
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= 1'b1;
      r_presc     <= w_us_tick ? '0 : r_presc + PW'(1);
      if (w_us_tick) begin
        r_period <= w_wrap ? '0 : r_period + W'(1);
        r_ramp   <= (r_ramp == RW'(RAMP_DIV - 1)) ? '0 : r_ramp + RW'(1);
      end
    end
  end

  // Channel targets, slewed widths, frame-latched widths, PWM and limit flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_tgt[i]     <= W'(MID);
        r_cur[i]     <= W'(MID);
        r_width_q[i] <= W'(MID);
      end
      r_servo   <= '0;
      r_max_lim <= '0;
      r_min_lim <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_cmd_hit[i])     r_tgt[i] <= w_cmd_tgt;
        else if (w_ramp_tick) r_tgt[i] <= w_btn_tgt[i];
        if (w_ramp_tick)      r_cur[i] <= w_slew_cur[i];
        if (w_wrap)           r_width_q[i] <= r_cur[i];
        r_servo[i]   <= (r_period < r_width_q[i]);
        r_max_lim[i] <= (r_cur[i] == W'(MAX_US));
        r_min_lim[i] <= (r_cur[i] == W'(MIN_US));
      end
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign servo     = r_servo;
  assign max_lim   = r_max_lim;
  assign min_lim   = r_min_lim;

endmodule

// File: tb/tb_servo_bank_ctrl.sv
// Directed bench for servo_bank_ctrl with scaled-down timing:
// 2 clocks per us, 100 us frame, 20 us ramp tick, widths 20..60 us, slew 4.
module tb_servo_bank_ctrl;

  localparam int unsigned SYS_CLK   = 2000000;
  localparam int unsigned NUM_CH    = 4;
  localparam int unsigned PERIOD_US = 100;
  localparam int unsigned MIN_US    = 20;
  localparam int unsigned MAX_US    = 60;
  localparam int unsigned STEP_US   = 1;
  localparam int unsigned SLEW_US   = 4;
  localparam int unsigned RAMP_HZ   = 50000;
  localparam int unsigned W         = 16;
  localparam int          CPU       = 2;   // clocks per us
  localparam int          MID       = 40;

  logic              clk;
  logic              reset_n;
  logic [NUM_CH-1:0] inc;
  logic [NUM_CH-1:0] dec;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_ch;
  logic [W-1:0]      cmd_width;
  logic [NUM_CH-1:0] servo;
  logic [NUM_CH-1:0] max_lim;
  logic [NUM_CH-1:0] min_lim;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;

  servo_bank_ctrl #(
    .SYS_CLK(SYS_CLK), .NUM_CH(NUM_CH), .PERIOD_US(PERIOD_US), .MIN_US(MIN_US),
    .MAX_US(MAX_US), .STEP_US(STEP_US), .SLEW_US(SLEW_US), .RAMP_HZ(RAMP_HZ), .W(W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .inc(inc), .dec(dec),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ch(cmd_ch), .cmd_width(cmd_width),
    .servo(servo), .max_lim(max_lim), .min_lim(min_lim)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock edges since reset release; edge k ends us tick when k is odd.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic wait_level(input int ch, input logic lvl, output int n);
    n = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      if (servo[ch] == lvl) begin
        n = k;
        break;
      end
    end
  endtask

  // High time of the next full pulse on a channel, in clocks (-1 on timeout).
  task automatic measure_width(input int ch, output int h);
    int a;
    h = -1;
    wait_level(ch, 1'b0, a);
    if (a < 0) return;
    wait_level(ch, 1'b1, a);
    if (a < 0) return;
    wait_level(ch, 1'b0, h);
  endtask

  task automatic measure_period(input int ch, output int p);
    int a;
    int b;
    p = -1;
    wait_level(ch, 1'b0, a);
    if (a < 0) return;
    wait_level(ch, 1'b1, a);
    if (a < 0) return;
    wait_level(ch, 1'b0, a);
    if (a < 0) return;
    wait_level(ch, 1'b1, b);
    if (b < 0) return;
    p = a + b;
  endtask

  task automatic wait_phase(input int md, input int val, output int ok);
    ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (cyc % md == val) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Drive one command for a single clock; caller is at a negedge.
  task automatic send_cmd(input int ch, input int width, input string tag);
    cmd_valid = 1'b1;
    cmd_ch    = 4'(ch);
    cmd_width = W'(width);
    check_eq({tag, "_ready"}, int'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Watch several frames: per-frame change bounded by 5 ticks * SLEW, then final width.
  task automatic track_slew(input int ch, input int fin_us, input string tag);
    int prev;
    int w;
    int d;
    measure_width(ch, prev);
    for (int f = 0; f < 4; f++) begin
      measure_width(ch, w);
      d = (w > prev) ? w - prev : prev - w;
      check_eq({tag, "_step_ok"}, int'(d <= 5 * int'(SLEW_US) * CPU), 1);
      prev = w;
    end
    check_eq({tag, "_final"}, prev, fin_us * CPU);
  endtask

  int w;
  int ok;

  initial begin
    reset_n   = 1'b0;
    inc       = '0;
    dec       = '0;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_width = '0;

    #32;
    check_eq("rst_servo", int'(servo), 0);
    check_eq("rst_ready", int'(cmd_ready), 0);
    check_eq("rst_max", int'(max_lim), 0);
    check_eq("rst_min", int'(min_lim), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("first_rise", int'(servo), 4'hF);
    check_eq("ready_after_rst", int'(cmd_ready), 1);

    // Idle: every channel at MID, frame 100 us.
    for (int ch = 0; ch < NUM_CH; ch++) begin
      measure_width(ch, w);
      check_eq($sformatf("idle_w%0d", ch), w, MID * CPU);
    end
    measure_period(0, w);
    check_eq("frame_period", w, int'(PERIOD_US) * CPU);
    check_eq("idle_max", int'(max_lim), 0);
    check_eq("idle_min", int'(min_lim), 0);

    // ch1 -> 56; others untouched.
    @(negedge clk);
    send_cmd(1, 56, "cmd1");
    repeat (600) @(negedge clk);
    measure_width(1, w);
    check_eq("ch1_56", w, 56 * CPU);
    measure_width(0, w);
    check_eq("ch0_still_mid", w, MID * CPU);

    // ch0 beyond top of W range clamps to MAX, then 0 clamps to MIN.
    @(negedge clk);
    send_cmd(0, 65535, "cmd_hi");
    track_slew(0, 60, "slew_up");
    check_eq("max_lim_hi", int'(max_lim), 4'b0001);
    check_eq("min_lim_hi", int'(min_lim), 4'b0000);
    @(negedge clk);
    send_cmd(0, 0, "cmd_lo");
    track_slew(0, 20, "slew_dn");
    check_eq("max_lim_lo", int'(max_lim), 4'b0000);
    check_eq("min_lim_lo", int'(min_lim), 4'b0001);

    // Hold inc[2] for 30 ramp ticks: saturates at MAX.
    @(negedge clk);
    inc[2] = 1'b1;
    repeat (1200) @(negedge clk);
    measure_width(2, w);
    check_eq("inc2_sat_a", w, 60 * CPU);
    repeat (400) @(negedge clk);
    inc[2] = 1'b0;
    measure_width(2, w);
    check_eq("inc2_sat_b", w, 60 * CPU);
    check_eq("inc2_max", int'(max_lim), 4'b0100);
    check_eq("inc2_min", int'(min_lim), 4'b0001);

    // Both buttons across one ramp tick recentre.
    inc[2] = 1'b1;
    dec[2] = 1'b1;
    repeat (40) @(negedge clk);
    inc[2] = 1'b0;
    dec[2] = 1'b0;
    repeat (600) @(negedge clk);
    measure_width(2, w);
    check_eq("both_mid", w, MID * CPU);
    check_eq("both_max", int'(max_lim), 0);

    // Out-of-range channel is accepted and dropped.
    @(negedge clk);
    send_cmd(9, 20, "cmd9");
    repeat (600) @(negedge clk);
    measure_width(0, w); check_eq("c9_w0", w, 20 * CPU);
    measure_width(1, w); check_eq("c9_w1", w, 56 * CPU);
    measure_width(2, w); check_eq("c9_w2", w, MID * CPU);
    measure_width(3, w); check_eq("c9_w3", w, MID * CPU);

    // Command on a ramp-tick edge beats inc[3] held on that same edge.
    wait_phase(40, 39, ok);
    check_eq("phase_tick", ok, 1);
    inc[3] = 1'b1;
    send_cmd(3, 24, "cmd3");
    inc[3] = 1'b0;
    repeat (600) @(negedge clk);
    measure_width(3, w);
    check_eq("cmd3_override", w, 24 * CPU);

    // Reset mid-frame at period_cnt ~30: ch1 and ch2 high, ch0 and ch3 low.
    wait_phase(200, 60, ok);
    check_eq("phase_mid", ok, 1);
    check_eq("pre_rst_servo", int'(servo), 4'b0110);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_servo", int'(servo), 0);
    check_eq("mid_rst_ready", int'(cmd_ready), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rerelease_rise", int'(servo), 4'hF);
    for (int ch = 0; ch < NUM_CH; ch++) begin
      measure_width(ch, w);
      check_eq($sformatf("post_rst_w%0d", ch), w, MID * CPU);
    end
    check_eq("post_rst_max", int'(max_lim), 0);
    check_eq("post_rst_min", int'(min_lim), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
